// File: rtl/psdsqrt_seq.sv
// Start/stop sequencer for the psdsqrt core: accepts an operand, times the core iteration window, returns the result.
// Optional LOAD-time self-check of the core result is enabled by defining PSDSQRT_SEQ_CHECK_EN.
module psdsqrt_seq #(
  parameter int NBITS_X = 32,
  parameter int NBITS_R = 16,
  parameter int NCYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NBITS_X-1:0] in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NBITS_R-1:0] out_sqrt,
  output logic               busy,
  output logic               core_start,
  output logic               core_stop,
  output logic [NBITS_X-1:0] core_x,
  input  logic [NBITS_R-1:0] core_sqrt,
  output logic               chk_err
);

  localparam int CW = $clog2(NCYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_LOAD,
    S_OUT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] counter;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nx = S_START;
      S_START: state_nx = S_RUN;
      S_RUN:   if (counter == CNT_LAST) state_nx = S_STOP;
      S_STOP:  state_nx = S_LOAD;
      S_LOAD:  state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_IDLE);
    busy       = (state != S_IDLE);
    core_start = (state == S_START);
    core_stop  = (state == S_STOP);
    out_valid  = (state == S_OUT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      counter  <= '0;
      core_x   <= '0;
      out_sqrt <= '0;
    end else begin
      if (state == S_IDLE && in_valid) core_x <= in_x;
      if (state == S_START)            counter <= '0;
      else if (state == S_RUN)         counter <= counter + 1'b1;
      if (state == S_LOAD)             out_sqrt <= core_sqrt;
    end
  end

`ifdef PSDSQRT_SEQ_CHECK_EN
  // One extra bit so (2^NBITS_R)^2 = 2^NBITS_X is representable.
  localparam int CKW = NBITS_X + 1;
  logic [CKW-1:0] chk_r, chk_r1, chk_lo, chk_hi, chk_x;
  logic           chk_fail;

  always_comb begin
    chk_r    = CKW'(core_sqrt);
    chk_r1   = chk_r + 1'b1;
    chk_lo   = chk_r * chk_r;
    chk_hi   = chk_r1 * chk_r1;
    chk_x    = CKW'(core_x);
    chk_fail = (chk_lo > chk_x) || (chk_hi <= chk_x);
  end

  always_ff @(posedge clock) begin
    if (!reset)                          chk_err <= 1'b0;
    else if (state == S_LOAD && chk_fail) chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Scoreboard bench for psdsqrt_seq with a behavioural psdsqrt core that loads floor-sqrt on core_stop.
module tb_psdsqrt_seq;
  localparam int NBITS_X = 32;
  localparam int NBITS_R = 16;
  localparam int NCYCLES = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [NBITS_X-1:0] in_x = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [NBITS_R-1:0] out_sqrt;
  logic               busy;
  logic               core_start;
  logic               core_stop;
  logic [NBITS_X-1:0] core_x;
  logic [NBITS_R-1:0] core_sqrt;
  logic               chk_err;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned pulse_viol = 0;
  logic [NBITS_R-1:0] sb[$];
  logic [NBITS_R-1:0] next_exp = '0;
  logic               core_bad = 1'b0;

  psdsqrt_seq #(.NBITS_X(NBITS_X), .NBITS_R(NBITS_R), .NCYCLES(NCYCLES)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_sqrt(out_sqrt), .busy(busy),
    .core_start(core_start), .core_stop(core_stop), .core_x(core_x),
    .core_sqrt(core_sqrt), .chk_err(chk_err)
  );

  always #5 clock = ~clock;

  function automatic logic [NBITS_R-1:0] isqrt(input logic [NBITS_X-1:0] x);
    longint r = 0;
    longint t;
    for (int b = NBITS_R - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return NBITS_R'(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Core model: output register loads on the stop pulse; optional corrupt answer for x=123456.
  always @(posedge clock) begin
    if (!reset) core_sqrt <= '0;
    else if (core_stop)
      core_sqrt <= (core_bad && core_x == 32'd123456) ? 16'd350 : isqrt(core_x);
  end

  // Scoreboard monitor, sampled on the falling edge ahead of the deciding rising edge.
  always @(negedge clock) begin
    if (!reset) sb.delete();
    else begin
      if (core_start && core_stop) pulse_viol++;
      if ((core_start || core_stop) && (in_ready || out_valid)) pulse_viol++;
      if (in_valid && in_ready) sb.push_back(next_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else check("out_sqrt", out_sqrt, sb.pop_front());
      end
    end
  end

  task automatic wait_accept();
    int unsigned n = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 100) begin check("accept_timeout", 0, 1); break; end
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clock); #1; n++; end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_op(input logic [NBITS_X-1:0] x, input logic [NBITS_R-1:0] e);
    in_x = x; next_exp = e; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic wait_out_valid();
    int unsigned n = 0;
    while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
  endtask

  initial begin
    int unsigned n, starts, stop_n, ov_n, last_acc, cyc, gap_bad;
    logic [NBITS_X-1:0] xs[5];
    logic [NBITS_R-1:0] es[5];

    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_core_x", core_x, 0);
    check("rst_out_sqrt", out_sqrt, 0);
    check("rst_pulses", {core_start, core_stop}, 0);
    check("rst_chk_err", chk_err, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Test 1: latency and pulse timing
    in_x = 32'd123456; next_exp = 16'd351; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("t1_start", core_start, 1);
    check("t1_core_x", core_x, 123456);
    check("t1_busy", busy, 1);
    n = 0; starts = 0; stop_n = 0; ov_n = 0;
    while (n < 40) begin
      @(posedge clock); #1; n++;
      if (core_start) starts++;
      if (core_stop && stop_n == 0) stop_n = n;
      if (out_valid) begin ov_n = n; break; end
    end
    check("t1_start_width", starts, 0);
    check("t1_stop_edge", stop_n, NCYCLES + 1);
    check("t1_valid_edge", ov_n, NCYCLES + 3);
    out_ready = 1'b1;
    wait_drain();

    // Test 2: boundary operands
    xs = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd65535, 32'd65536};
    es = '{16'd0, 16'd65535, 16'd1, 16'd255, 16'd256};
    foreach (xs[i]) run_op(xs[i], es[i]);

    // Test 3: output stall with ignored operand pulse
    in_x = 32'd1000000; next_exp = 16'd1000; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept();
    in_valid = 1'b0;
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_x = 32'd49; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clock); #1;
      check("t3_valid", out_valid, 1);
      check("t3_sqrt", out_sqrt, 1000);
      check("t3_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("t3_core_x", core_x, 1000000);
    out_ready = 1'b1;
    wait_drain();
    @(posedge clock); #1;
    check("t3_idle_after", {busy, in_ready}, 2'b01);

    // Test 4: reset during RUN
    in_x = 32'd99999; next_exp = isqrt(32'd99999); in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    check("t4_in_ready", in_ready, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_pulses", {core_start, core_stop}, 0);
    check("t4_core_x", core_x, 0);
    repeat (NCYCLES + 5) begin
      @(posedge clock); #1;
      if (out_valid) check("t4_stale_out", out_valid, 0);
    end
    run_op(32'd144, 16'd12);

    // Test 5: back-to-back random with exact issue interval
    in_valid = 1'b1; out_ready = 1'b1;
    gap_bad = 0; last_acc = 0; cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      in_x = $urandom; next_exp = isqrt(in_x);
      n = 0;
      forever begin
        @(negedge clock);
        if (in_ready) break;
        n++; cyc++;
        if (n > 100) begin check("t5_timeout", 0, 1); break; end
      end
      if (i > 0 && cyc - last_acc != NCYCLES + 5) gap_bad++;
      last_acc = cyc;
      @(posedge clock); #1; cyc++;
    end
    in_valid = 1'b0;
    wait_drain();
    check("t5_interval", gap_bad, 0);
    check("pulse_rules", pulse_viol, 0);
    check("chk_err_clean", chk_err, 0);

`ifdef PSDSQRT_SEQ_CHECK_EN
    // Test 6: corrupted core result sets sticky chk_err
    core_bad = 1'b1;
    in_x = 32'd123456; next_exp = 16'd350; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept();
    in_valid = 1'b0;
    wait_out_valid();
    check("t6_chk_err_set", chk_err, 1);
    out_ready = 1'b1;
    wait_drain();
    core_bad = 1'b0;
    run_op(32'd144, 16'd12);
    run_op(32'd123456, 16'd351);
    check("t6_chk_err_sticky", chk_err, 1);
    pulse_reset();
    check("t6_chk_err_clear", chk_err, 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
